button_conditioner: RTL and testbench

//  Conditions the raw active-low pushbuttons (start, move, select) before the game

---
 rtl/button_pkg.sv | 20 ++
 rtl/button_channel.sv | 128 ++++++++++++
 rtl/button_conditioner.sv | 41 ++++
 tb/tb_button_conditioner.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and helpers for the pushbutton conditioning path.
package button_pkg;

    // Board clock used to derive the default timing parameters.
    localparam int CLK_HZ = 50_000_000;

    // Per-channel debounce state.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM_PRESS = 2'd1,
        HELD      = 2'd2,
        ARM_REL   = 2'd3
    } btn_state_t;

    // Converts a duration in milliseconds into clock cycles at clk_hz.
    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One pushbutton channel: 2-FF synchronizer, counter debounce,
// press/release strobes and optional hold-to-repeat strobes.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    parameter bit REPEAT_EN       = 1'b0
)(
    input  logic clk,
    input  logic hrd_rst_n,
    input  logic btn_n,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RP_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] REP_LAST   = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] REP_RELOAD = RP_W'(REPEAT_DELAY - REPEAT_PERIOD);

    generate
        if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_params
            $error("button_channel: illegal debounce/repeat parameters");
        end
    endgenerate

    logic            sync1_reg;
    logic            sync2_reg;
    btn_state_t      state_reg;
    logic [DB_W-1:0] db_cnt_reg;
    logic [RP_W-1:0] rep_cnt_reg;
    logic            level_reg;
    logic            press_reg;
    logic            release_reg;
    logic            repeat_reg;

    // Bring the asynchronous pin into clk, inverted to active-high; reset to released.
    always_ff @(posedge clk) begin
        if (!hrd_rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= ~btn_n;
            sync2_reg <= sync1_reg;
        end
    end

    // Debounce FSM with registered level/strobe outputs and hold-repeat counter.
    always_ff @(posedge clk) begin
        if (!hrd_rst_n) begin
            state_reg   <= IDLE;
            db_cnt_reg  <= '0;
            rep_cnt_reg <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            repeat_reg  <= 1'b0;
        end else begin
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            repeat_reg  <= 1'b0;

            unique case (state_reg)
                IDLE: begin
                    if (sync2_reg) begin
                        state_reg  <= ARM_PRESS;
                        db_cnt_reg <= '0;
                    end
                end
                ARM_PRESS: begin
                    if (!sync2_reg) begin
                        state_reg <= IDLE;
                    end else if (db_cnt_reg == DB_LAST) begin
                        state_reg   <= HELD;
                        level_reg   <= 1'b1;
                        press_reg   <= 1'b1;
                        rep_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end
                HELD: begin
                    if (!sync2_reg) begin
                        state_reg  <= ARM_REL;
                        db_cnt_reg <= '0;
                    end
                end
                ARM_REL: begin
                    if (sync2_reg) begin
                        state_reg <= HELD;
                    end else if (db_cnt_reg == DB_LAST) begin
                        state_reg   <= IDLE;
                        level_reg   <= 1'b0;
                        release_reg <= 1'b1;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            // Hold timer keeps running through a release bounce; the reload
            // after the first tick spaces later ticks by the repeat period.
            if (REPEAT_EN && (state_reg == HELD || state_reg == ARM_REL)) begin
                if (rep_cnt_reg == REP_LAST) begin
                    repeat_reg  <= 1'b1;
                    rep_cnt_reg <= REP_RELOAD;
                end else begin
                    rep_cnt_reg <= rep_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign btn_level   = level_reg;
    assign btn_press   = press_reg;
    assign btn_release = release_reg;
    assign btn_repeat  = repeat_reg;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw active-low game pushbuttons into debounced levels and
// single-cycle press/release/repeat strobes, one independent channel per key.
module button_conditioner
    import button_pkg::*;
#(
    parameter int                 NUM_BTN         = 3,
    parameter int                 DEBOUNCE_CYCLES = ms_to_cycles(CLK_HZ, 10),
    parameter int                 REPEAT_DELAY    = ms_to_cycles(CLK_HZ, 500),
    parameter int                 REPEAT_PERIOD   = ms_to_cycles(CLK_HZ, 200),
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 3'b010
)(
    input  logic               clk,
    input  logic               hrd_rst_n,
    input  logic [NUM_BTN-1:0] btn_n,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            button_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD),
                .REPEAT_EN       (REPEAT_MASK[gi])
            ) u_chan (
                .clk         (clk),
                .hrd_rst_n   (hrd_rst_n),
                .btn_n       (btn_n[gi]),
                .btn_level   (btn_level[gi]),
                .btn_press   (btn_press[gi]),
                .btn_release (btn_release[gi]),
                .btn_repeat  (btn_repeat[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed vector table,
// hand-written multi-cycle corner cases and randomized key activity
// checked every cycle against a run-length reference model.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic       clk = 1'b0;
    logic       hrd_rst_n = 1'b0;
    logic [2:0] btn_n = 3'b111;
    logic [2:0] btn_level, btn_press, btn_release, btn_repeat;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BTN         (3),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_MASK     (3'b010)
    ) dut (
        .clk         (clk),
        .hrd_rst_n   (hrd_rst_n),
        .btn_n       (btn_n),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    // ---------------- reference model ----------------
    // Sync is a two-deep delay line; a level flips once D+1 consecutive
    // synchronized samples disagree with it; repeat ticks are derived from
    // the number of edges elapsed since the press edge.
    logic [2:0] rep_mask = 3'b010;
    logic [2:0] h1 = '0, h2 = '0, lv = '0;
    int         run [3];
    int         age [3];
    logic [2:0] m_level = '0, m_press = '0, m_release = '0, m_repeat = '0;

    task automatic model_edge(input logic [2:0] bn, input logic rn);
        m_press   = '0;
        m_release = '0;
        m_repeat  = '0;
        if (!rn) begin
            h1 = '0;
            h2 = '0;
            lv = '0;
            for (int c = 0; c < 3; c++) begin
                run[c] = 0;
                age[c] = 0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (lv[c] && rep_mask[c]) begin
                    age[c]++;
                    if (age[c] == RD || (age[c] > RD && (age[c] - RD) % RP == 0))
                        m_repeat[c] = 1'b1;
                end
                if (h2[c] != lv[c]) run[c]++;
                else run[c] = 0;
                if (run[c] == D + 1) begin
                    run[c] = 0;
                    lv[c]  = ~lv[c];
                    if (lv[c]) begin
                        m_press[c] = 1'b1;
                        age[c]     = 0;
                    end else begin
                        m_release[c] = 1'b1;
                    end
                end
                h2[c] = h1[c];
                h1[c] = ~bn[c];
            end
        end
        m_level = lv;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [2:0] got, input logic [2:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    // Drive one cycle of inputs, advance the model, compare all outputs after the edge.
    task automatic step(input logic [2:0] bn, input logic rn);
        @(negedge clk);
        btn_n     = bn;
        hrd_rst_n = rn;
        model_edge(bn, rn);
        @(posedge clk);
        #1;
        cyc++;
        chk("model_level",   btn_level,   m_level);
        chk("model_press",   btn_press,   m_press);
        chk("model_release", btn_release, m_release);
        chk("model_repeat",  btn_repeat,  m_repeat);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [2:0] bn;
        logic       rn;
        logic [2:0] lvl;
        logic [2:0] prs;
        logic [2:0] rel;
        logic [2:0] rep;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [2:0] bn, input logic rn, input logic [2:0] lvl,
                       input logic [2:0] prs, input logic [2:0] rel, input int n);
        vec_t v;
        v.bn  = bn;
        v.rn  = rn;
        v.lvl = lvl;
        v.prs = prs;
        v.rel = rel;
        v.rep = 3'b000;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        int n_rel, n_prs, rel_at, prs_at;
        logic [2:0] cur;
        int hold [3];
        logic rn;

        // Reset with all keys down, then press strobe 6 cycles after deassertion.
        add(3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 2);
        add(3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 6);
        add(3'b000, 1'b1, 3'b111, 3'b111, 3'b000, 1);
        // Release all: release strobe 6 cycles after the rising edge.
        add(3'b111, 1'b1, 3'b111, 3'b000, 3'b000, 6);
        add(3'b111, 1'b1, 3'b000, 3'b000, 3'b111, 1);
        add(3'b111, 1'b1, 3'b000, 3'b000, 3'b000, 3);
        // Clean press of ch1 held 8 cycles, then release.
        add(3'b101, 1'b1, 3'b000, 3'b000, 3'b000, 6);
        add(3'b101, 1'b1, 3'b010, 3'b010, 3'b000, 1);
        add(3'b101, 1'b1, 3'b010, 3'b000, 3'b000, 1);
        add(3'b111, 1'b1, 3'b010, 3'b000, 3'b000, 6);
        add(3'b111, 1'b1, 3'b000, 3'b000, 3'b010, 1);
        add(3'b111, 1'b1, 3'b000, 3'b000, 3'b000, 2);
        // Glitch on ch0 shorter than the debounce window.
        add(3'b110, 1'b1, 3'b000, 3'b000, 3'b000, 3);
        add(3'b111, 1'b1, 3'b000, 3'b000, 3'b000, 10);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].bn, tbl[i].rn);
            chk($sformatf("tbl%0d_level", i),   btn_level,   tbl[i].lvl);
            chk($sformatf("tbl%0d_press", i),   btn_press,   tbl[i].prs);
            chk($sformatf("tbl%0d_release", i), btn_release, tbl[i].rel);
            chk($sformatf("tbl%0d_repeat", i),  btn_repeat,  tbl[i].rep);
        end

        // Release bounce on ch2: one release, 6 cycles after the final rising edge.
        for (int i = 0; i < 8; i++) step(3'b011, 1'b1);
        chk("bounce_level_held", btn_level, 3'b100);
        n_rel = 0; n_prs = 0; rel_at = -1;
        for (int k = 0; k < 14; k++) begin
            step((k < 2 || k >= 4) ? 3'b111 : 3'b011, 1'b1);
            if (btn_release[2]) begin
                n_rel++;
                rel_at = k;
            end
            if (btn_press[2]) n_prs++;
        end
        chk_int("bounce_release_count", n_rel, 1);
        chk_int("bounce_release_cycle", rel_at, 10);
        chk_int("bounce_no_repress", n_prs, 0);

        // Hold ch0 and ch1: only ch1 repeats, at press+10 then every 5 cycles.
        for (int c = 0; c < 47; c++) begin
            logic exp_rep;
            step(3'b100, 1'b1);
            exp_rep = (c >= 16) && ((c - 16) % 5 == 0);
            chk("hold_repeat", btn_repeat, {1'b0, exp_rep, 1'b0});
            chk("hold_press", btn_press, (c == 6) ? 3'b011 : 3'b000);
        end
        for (int i = 0; i < 10; i++) step(3'b111, 1'b1);
        chk("hold_released", btn_level, 3'b000);

        // Reset while ch1 is held: outputs clear, no release, fresh press later.
        for (int i = 0; i < 8; i++) step(3'b101, 1'b1);
        chk("rst_hold_level", btn_level, 3'b010);
        step(3'b101, 1'b0);
        chk("rst_hold_cleared", btn_level | btn_press | btn_release | btn_repeat, 3'b000);
        n_rel = 0; n_prs = 0; prs_at = -1;
        for (int j = 0; j < 10; j++) begin
            step(3'b101, 1'b1);
            if (btn_release != 3'b000) n_rel++;
            if (btn_press[1]) begin
                n_prs++;
                prs_at = j;
            end
        end
        chk_int("rst_hold_no_release", n_rel, 0);
        chk_int("rst_hold_press_count", n_prs, 1);
        chk_int("rst_hold_press_cycle", prs_at, 6);
        for (int i = 0; i < 10; i++) step(3'b111, 1'b1);

        // Randomized key activity with occasional resets, checked against the model.
        cur = 3'b111;
        for (int c = 0; c < 3; c++) hold[c] = 0;
        for (int t = 0; t < 4000; t++) begin
            for (int c = 0; c < 3; c++) begin
                if (hold[c] == 0) begin
                    cur[c]  = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(1, 30);
                end
                hold[c]--;
            end
            rn = ($urandom_range(0, 299) != 0);
            step(cur, rn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
